// File: rtl/fp_align_seq.sv
// Sequential FP32 operand aligner: swaps by magnitude, then right-shifts the smaller mantissa with sticky.
// Optional FP_ALIGN_BARREL_EN collapses the 4-bit-per-cycle shifter into a single-cycle barrel shift.
module fp_align_seq (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [26:0] mant_large_o,
    output logic [26:0] mant_small_o,
    output logic [7:0]  exp_o,
    output logic        sign_large_o,
    output logic        sign_small_o,
    output logic        swap_o,
    output logic        equal_o
);
    typedef enum logic [1:0] {IDLE, ALIGN, DONE} state_t;

    state_t      state;
    logic [4:0]  remaining;

    logic        a_ge_b;
    logic [31:0] op_big, op_lit;
    logic [7:0]  diff;
    logic [26:0] m_big, m_lit;

    always_comb begin
        a_ge_b = a_i[30:0] >= b_i[30:0];
        op_big = a_ge_b ? a_i : b_i;
        op_lit = a_ge_b ? b_i : a_i;
        diff   = op_big[30:23] - op_lit[30:23];
        m_big  = {|op_big[30:23], op_big[22:0], 3'b000};
        m_lit  = {|op_lit[30:23], op_lit[22:0], 3'b000};
    end

    logic [4:0]  shift_amt;
    logic [26:0] low_mask;
    logic        sticky;
    logic [26:0] shifted;

    always_comb begin
`ifdef FP_ALIGN_BARREL_EN
        shift_amt = remaining;
`else
        shift_amt = (remaining > 5'd4) ? 5'd4 : remaining;
`endif
        low_mask = (27'd1 << shift_amt) - 27'd1;
        sticky   = |(mant_small_o & low_mask);
        // Bit 0 already holds earlier sticky, so folding it in again keeps the OR cumulative.
        shifted  = (mant_small_o >> shift_amt) | {26'b0, sticky};
    end

    assign in_ready_o  = (state == IDLE);
    assign out_valid_o = (state == DONE);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            remaining    <= '0;
            mant_large_o <= '0;
            mant_small_o <= '0;
            exp_o        <= '0;
            sign_large_o <= 1'b0;
            sign_small_o <= 1'b0;
            swap_o       <= 1'b0;
            equal_o      <= 1'b0;
        end else if (flush_i) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    mant_large_o <= m_big;
                    exp_o        <= op_big[30:23];
                    sign_large_o <= op_big[31];
                    sign_small_o <= op_lit[31];
                    swap_o       <= ~a_ge_b;
                    equal_o      <= (a_i[30:0] == b_i[30:0]);
                    remaining    <= diff[4:0];
                    if (diff == 8'd0) begin
                        mant_small_o <= m_lit;
                        state        <= DONE;
                    end else if (diff >= 8'd27) begin
                        mant_small_o <= {26'b0, |m_lit};
                        state        <= DONE;
                    end else begin
                        mant_small_o <= m_lit;
                        state        <= ALIGN;
                    end
                end
                ALIGN: begin
                    mant_small_o <= shifted;
                    remaining    <= remaining - shift_amt;
                    if (remaining == shift_amt) state <= DONE;
                end
                DONE: if (out_ready_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_align_seq.sv
// Directed bench for fp_align_seq with an arithmetic reference model and a per-cycle output checker.
module tb_fp_align_seq;
    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] a_i, b_i;
    logic        in_valid_i, in_ready_o, flush_i, out_valid_o, out_ready_i;
    logic [26:0] mant_large_o, mant_small_o;
    logic [7:0]  exp_o;
    logic        sign_large_o, sign_small_o, swap_o, equal_o;

`ifdef FP_ALIGN_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif
    localparam logic [31:0] NO_LIT = 32'hFFFF_FFFF;

    fp_align_seq dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .a_i(a_i), .b_i(b_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .flush_i(flush_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .mant_large_o(mant_large_o), .mant_small_o(mant_small_o), .exp_o(exp_o),
        .sign_large_o(sign_large_o), .sign_small_o(sign_small_o),
        .swap_o(swap_o), .equal_o(equal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [26:0] ml, ms;
        logic [7:0]  ex;
        logic        sl, ss, sw, eq;
        int          lat;
    } exp_t;

    exp_t cur;
    bit   chk_en = 1'b0;
    int   vecs = 0, errs = 0;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        logic [31:0] l, s;
        int d;
        longint unsigned ms, lost;
        e.sw = !(a[30:0] >= b[30:0]);
        l = e.sw ? b : a;
        s = e.sw ? a : b;
        e.eq = (a[30:0] == b[30:0]);
        e.ex = l[30:23];
        e.sl = l[31];
        e.ss = s[31];
        d  = int'(l[30:23]) - int'(s[30:23]);
        e.ml = {(l[30:23] != 0), l[22:0], 3'b000};
        ms = 64'({(s[30:23] != 0), s[22:0], 3'b000});
        if (d >= 27) begin
            e.ms = (ms != 0) ? 27'd1 : 27'd0;
        end else begin
            lost = ms & ((64'd1 << d) - 64'd1);
            e.ms = 27'((ms >> d) | ((lost != 0) ? 64'd1 : 64'd0));
        end
        if (d == 0 || d >= 27) e.lat = 1;
        else if (BARREL)       e.lat = 2;
        else                   e.lat = (d + 3) / 4 + 1;
        return e;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        vecs++;
        if (act !== want) begin
            errs++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Every DONE cycle must match the model; this also proves outputs hold while stalled.
    always @(negedge clk_i) begin
        if (chk_en && out_valid_o) begin
            check("mant_large", 32'(mant_large_o), 32'(cur.ml));
            check("mant_small", 32'(mant_small_o), 32'(cur.ms));
            check("exp",        32'(exp_o),        32'(cur.ex));
            check("sign_large", 32'(sign_large_o), 32'(cur.sl));
            check("sign_small", 32'(sign_small_o), 32'(cur.ss));
            check("swap",       32'(swap_o),       32'(cur.sw));
            check("equal",      32'(equal_o),      32'(cur.eq));
        end
    end

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input logic [31:0] lit_ms, input int lit_lat);
        int lat;
        cur = model(a, b);
        @(negedge clk_i);
        check("in_ready_idle", 32'(in_ready_o), 32'd1);
        a_i = a; b_i = b; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        chk_en = 1'b1;
        // Keep in_valid high with junk operands: must be ignored while busy.
        a_i = $urandom; b_i = $urandom;
        lat = 1;
        while (!out_valid_o && lat < 64) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(cur.lat));
        if (lit_lat >= 0) check("latency_lit", 32'(lat), 32'(lit_lat));
        if (lit_ms != NO_LIT) check("mant_small_lit", 32'(mant_small_o), lit_ms);
        repeat (hold) @(posedge clk_i);
        #1;
        check("hold_valid", 32'(out_valid_o), 32'd1);
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b0;
        chk_en      = 1'b0;
        check("post_hs_ready", 32'(in_ready_o), 32'd1);
        check("post_hs_valid", 32'(out_valid_o), 32'd0);
    endtask

    // Abort a diff-24 op mid-ALIGN via flush (use_rst=0) or async reset (use_rst=1).
    task automatic abort_op(input bit use_rst);
        bit saw = 1'b0;
        @(negedge clk_i);
        a_i = 32'h4B80_0000; b_i = 32'h3F80_0000; in_valid_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        if (!BARREL) begin
            @(posedge clk_i); #1;
        end
        check("abort_in_align", 32'(in_ready_o), 32'd0);
        if (use_rst) begin
            #2 rst_ni = 1'b0;
            #1;
            check("rst_ready",      32'(in_ready_o),   32'd1);
            check("rst_valid",      32'(out_valid_o),  32'd0);
            check("rst_mant_small", 32'(mant_small_o), 32'd0);
            check("rst_mant_large", 32'(mant_large_o), 32'd0);
            check("rst_exp",        32'(exp_o),        32'd0);
            @(negedge clk_i) rst_ni = 1'b1;
        end else begin
            flush_i = 1'b1;
            @(posedge clk_i); #1;
            flush_i = 1'b0;
            check("flush_ready", 32'(in_ready_o),  32'd1);
            check("flush_valid", 32'(out_valid_o), 32'd0);
        end
        repeat (10) begin
            @(negedge clk_i);
            saw |= out_valid_o;
        end
        check("abort_no_valid", 32'(saw), 32'd0);
    endtask

    initial begin
        a_i = '0; b_i = '0; in_valid_i = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0;
        rst_ni = 1'b0;
        #12;
        check("reset_ready",      32'(in_ready_o),   32'd1);
        check("reset_valid",      32'(out_valid_o),  32'd0);
        check("reset_mant_large", 32'(mant_large_o), 32'd0);
        check("reset_mant_small", 32'(mant_small_o), 32'd0);
        check("reset_exp",        32'(exp_o),        32'd0);
        @(negedge clk_i) rst_ni = 1'b1;

        // Pin the model against hand-derived values.
        cur = model(32'h4000_0000, 32'h3F80_0000);
        check("model_ml",  32'(cur.ml), 32'h400_0000);
        check("model_ms",  32'(cur.ms), 32'h200_0000);
        check("model_exp", 32'(cur.ex), 32'h80);
        cur = model(32'h5380_0000, 32'h3F80_0001);
        check("model_ms_d40", 32'(cur.ms), 32'h1);

        run_op(32'h4000_0000, 32'h3F80_0000, 0, 32'h200_0000, 2);
        run_op(32'h3F80_0000, 32'h4000_0000, 0, 32'h200_0000, 2);
        run_op(32'h4B80_0000, 32'h3F80_0000, 0, 32'h000_0004, BARREL ? 2 : 7);
        run_op(32'h5380_0000, 32'h3F80_0001, 0, 32'h000_0001, 1);
        run_op(32'h3F80_0000, 32'h3F80_0000, 5, 32'h400_0000, 1);
        run_op(32'h3F80_0000, 32'h3F00_0001, 0, NO_LIT, -1);   // diff 1
        run_op(32'h4180_0000, 32'h3F80_0007, 2, NO_LIT, -1);   // diff 4, sticky
        run_op(32'h4200_0000, 32'h3F80_0007, 0, NO_LIT, -1);   // diff 5
        run_op(32'h4120_0000, 32'hBDCC_CCCD, 0, NO_LIT, -1);   // mixed signs
        run_op(32'hC000_0000, 32'h3FFF_FFFF, 0, NO_LIT, -1);
        run_op(32'h4C80_0000, 32'h3F80_0001, 0, NO_LIT, -1);   // diff 26
        run_op(32'h4D00_0000, 32'h3F80_0001, 0, NO_LIT, -1);   // diff 27
        run_op(32'h0000_0003, 32'h0080_0000, 0, NO_LIT, -1);   // subnormal vs normal
        run_op(32'h8000_0000, 32'h0000_0000, 0, NO_LIT, -1);   // signed zeros
        run_op(32'h3F80_0000, 32'h4000_0000, 1, NO_LIT, -1);

        abort_op(1'b0);
        abort_op(1'b1);
        run_op(32'h4B80_0000, 32'h3F80_0000, 0, 32'h000_0004, BARREL ? 2 : 7);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
